// File: rtl/serial_comparator_der_izq_pkg.sv
// Shared definitions for the serial right-to-left magnitude comparator:
// FSM encoding and bit positions inside the captured mode register.
package serial_comparator_der_izq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MODE_LE     = 0;
  localparam int MODE_SIGNED = 1;
  localparam int MODE_W      = 2;

endpackage

// File: rtl/serial_comparator_der_izq_cell.sv
// One bit of the LSB-first "A below B" recurrence; inv swaps operand
// polarity so the two's-complement sign bit compares the other way round.
module comparator_cell (
  input  logic p_in,
  input  logic a_i,
  input  logic b_i,
  input  logic inv,
  output logic p_out
);

  logic w_a, w_b;

  assign w_a   = a_i ^ inv;
  assign w_b   = b_i ^ inv;
  // A higher differing bit decides; equal bits pass the lower verdict through.
  assign p_out = (~w_a & w_b) | (p_in & (~w_a | w_b));

endmodule

// File: rtl/serial_comparator_der_izq.sv
// Multi-cycle A<B / A<=B comparator walking DIGIT bits per clock from LSB
// to MSB, with start/busy/done handshake and signed/unsigned modes.
module serial_comparator_der_izq
  import serial_comparator_der_izq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode_le,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             z
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (WIDTH < 2) begin : g_chk_width
      $error("serial_comparator_der_izq: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_chk_digit
      $error("serial_comparator_der_izq: DIGIT must divide WIDTH");
    end
  endgenerate

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [MODE_W-1:0] r_mode;
  logic [CW-1:0]     r_cnt;
  logic              r_p, r_busy, r_done, r_z;
  logic              w_last, w_accept;
  logic [DIGIT:0]    w_p;

  assign w_last   = (r_cnt == CW'(K - 1));
  assign w_accept = (r_state != RUN) && (w_state_nxt == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = start ? RUN : IDLE;
      RUN:     w_state_nxt = w_last ? DONE : RUN;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Digit chain: the sign-bit swap applies only to the top bit of the last digit.
  assign w_p[0] = r_p;
  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
      logic w_inv;
      if (i == DIGIT - 1) begin : g_top
        assign w_inv = r_mode[MODE_SIGNED] & w_last;
      end else begin : g_low
        assign w_inv = 1'b0;
      end
      comparator_cell u_cell (
        .p_in  (w_p[i]),
        .a_i   (r_a[i]),
        .b_i   (r_b[i]),
        .inv   (w_inv),
        .p_out (w_p[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
      r_cnt  <= '0;
      r_p    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_z    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_mode <= {signed_mode, mode_le};
        r_cnt  <= '0;
        // Empty lower slice counts as equal, so <= starts true and < starts false.
        r_p    <= mode_le;
      end else if (r_state == RUN) begin
        r_a <= r_a >> DIGIT;
        r_b <= r_b >> DIGIT;
        r_p <= w_p[DIGIT];
        if (w_last) r_z   <= w_p[DIGIT];
        else        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign z    = r_z;

endmodule
